rc_pulse_decoder: RTL



---
 rtl/rc_pulse_decoder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/rc_pulse_decoder.sv
// rc_pulse_decoder: measures the high time of one RC/servo input channel in
// microseconds. Accepted widths are published with a one-cycle strobe. Widths
// out of range are flagged with a one-cycle error strobe. A level output shows
// when no good pulse has arrived for too long.
// Optional feature: define RC_GLITCH_FILTER_EN to add a 4-sample glitch filter
// after the synchronizer. It rejects pulses and gaps of 3 cycles or fewer.
module rc_pulse_decoder #(
   parameter int CLK_DIV    = 50,
   parameter int MIN_US     = 800,
   parameter int MAX_US     = 2200,
   parameter int TIMEOUT_US = 25000,
   parameter int W          = 12
) (
   input  logic         sys_clk,
   input  logic         sys_rst_n,
   input  logic         rc_in,
   output logic [W-1:0] pulse_us,
   output logic         pulse_valid,
   output logic         pulse_err,
   output logic         signal_lost
);

   localparam int PW = $clog2(CLK_DIV + 1);
   localparam int LW = $clog2(TIMEOUT_US + 1);

   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [W-1:0]  MIN_W      = W'(MIN_US);
   localparam logic [W-1:0]  MAX_W      = W'(MAX_US);
   localparam logic [W-1:0]  OVF_W      = W'(MAX_US + 1);
   localparam logic [LW-1:0] TIMEOUT_L  = LW'(TIMEOUT_US);

   typedef enum logic [1:0] {
      ARM  = 2'd0,
      IDLE = 2'd1,
      HIGH = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          prev_q, prev_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [W-1:0]  width_q, width_d;
   logic [W-1:0]  pulse_us_q, pulse_us_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic [LW-1:0] lost_cnt_q, lost_cnt_d;
   logic          lost_q, lost_d;

`ifdef RC_GLITCH_FILTER_EN
   logic [1:0]    fcnt_q, fcnt_d;
`endif

   logic          sig;
   logic          rise;
   logic          fall;
   logic          tick;
   logic [W-1:0]  width_inc;

   // Input path: 2-FF synchronizer, optional glitch filter, edge detection.
   always_comb begin
      sync1_d = rc_in;
      sync2_d = sync1_q;
      sig     = sync2_q;
`ifdef RC_GLITCH_FILTER_EN
      // prev_q is the filter output. It flips on the 4th consecutive sample
      // that disagrees with it. That adds 3 cycles to both edges.
      sig    = prev_q;
      fcnt_d = '0;
      if (sync2_q != prev_q) begin
         if (fcnt_q == 2'd3) begin
            sig = sync2_q;
         end else begin
            fcnt_d = fcnt_q + 2'd1;
         end
      end
`endif
      prev_d = sig;
      rise   = sig & ~prev_q;
      fall   = ~sig & prev_q;
   end

   // Prescaler, pulse-measurement FSM and loss-of-signal tracking.
   always_comb begin
      presc_d = presc_q + 1'b1;
      if (rise || presc_q == PRESC_LAST) begin
         presc_d = '0;
      end
      tick      = (presc_q == PRESC_LAST);
      width_inc = width_q + {{(W-1){1'b0}}, tick};

      state_d    = state_q;
      width_d    = width_q;
      pulse_us_d = pulse_us_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         // The synchronizer clears on reset, so a low sample right after
         // release proves nothing. Leave ARM only on a tick, once the
         // pipeline has refilled, with the input seen low. A pulse that
         // was already running at reset is then never measured.
         ARM: begin
            if (tick && !sig && !sync2_q) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (rise) begin
               width_d = '0;
               state_d = HIGH;
            end
         end
         HIGH: begin
            width_d = width_inc;
            if (fall) begin
               // A tick in the fall cycle still counts.
               // That gives floor(high_cycles / CLK_DIV).
               state_d = IDLE;
               if (width_inc < MIN_W || width_inc > MAX_W) begin
                  err_d = 1'b1;
               end else begin
                  valid_d    = 1'b1;
                  pulse_us_d = width_inc;
               end
            end else if (width_inc == OVF_W) begin
               err_d   = 1'b1;
               state_d = ARM;
            end
         end
         default: begin
            state_d = ARM;
         end
      endcase

      lost_cnt_d = lost_cnt_q;
      if (tick && lost_cnt_q != TIMEOUT_L) begin
         lost_cnt_d = lost_cnt_q + 1'b1;
      end
      if (valid_d) begin
         lost_cnt_d = '0;
      end
      // Sticky until the next accepted pulse. It is high out of reset.
      lost_d = valid_d ? 1'b0 : (lost_q | (lost_cnt_d == TIMEOUT_L));
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= ARM;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         prev_q     <= 1'b0;
         presc_q    <= '0;
         width_q    <= '0;
         pulse_us_q <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         lost_cnt_q <= '0;
         lost_q     <= 1'b1;
`ifdef RC_GLITCH_FILTER_EN
         fcnt_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         prev_q     <= prev_d;
         presc_q    <= presc_d;
         width_q    <= width_d;
         pulse_us_q <= pulse_us_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         lost_cnt_q <= lost_cnt_d;
         lost_q     <= lost_d;
`ifdef RC_GLITCH_FILTER_EN
         fcnt_q     <= fcnt_d;
`endif
      end
   end

   assign pulse_us    = pulse_us_q;
   assign pulse_valid = valid_q;
   assign pulse_err   = err_q;
   assign signal_lost = lost_q;

endmodule
